csr_file: RTL



---
 rtl/turtle_csr_pkg.sv | 38 +++
 rtl/csr_counter64.sv | 28 ++
 rtl/csr_file.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/turtle_csr_pkg.sv
// Shared constants for the TURTLE machine-mode CSR file: addresses, masks,
// fixed read values and the read-channel state encoding.
package turtle_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL      = 32'h4000_0100;
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
    localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

    localparam logic [1:0]  RRESP_OKAY    = 2'b00;
    localparam logic [1:0]  RRESP_SLVERR  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write
// to either half takes precedence over the increment in that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) r_count[31:0]  <= wdata;
            if (wr_hi) r_count[63:32] <= wdata;
        end else if (inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: AXI4-Lite read responder, write sink, trap/mret
// state updates and the cycle/instret counters.
//   state | meaning
//   IDLE  | accepting a read address (arready high)
//   RESP  | holding rdata/rresp until rready (rvalid high)
module csr_file
    import turtle_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] axil_csr_araddr,
    input  logic        axil_csr_arvalid,
    output logic        axil_csr_arready,
    output logic [31:0] axil_csr_rdata,
    output logic [1:0]  axil_csr_rresp,
    output logic        axil_csr_rvalid,
    input  logic        axil_csr_rready,
    input  logic [11:0] csr_write_addr,
    input  logic [31:0] csr_write_val,
    input  logic        csr_write_valid,
    input  logic        instret_inc,
    input  logic [2:0]  irq_pending,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mstatus_mie_out,
    output logic [31:0] mie_out
);

    rd_state_e   r_state, w_state_next;
    logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [31:0] r_rdata, w_rdata;
    logic [1:0]  r_rresp, w_rresp;
    logic [63:0] w_mcycle, w_minstret;
    logic [31:0] w_mip;
    logic        w_ar_hs;

    function automatic logic wr_hit(input logic [11:0] a);
        return csr_write_valid && (csr_write_addr == a);
    endfunction

    csr_counter64 u_mcycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (wr_hit(CSR_MCYCLE)),
        .wr_hi (wr_hit(CSR_MCYCLEH)),
        .wdata (csr_write_val),
        .count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .reset (reset),
        .inc   (instret_inc),
        .wr_lo (wr_hit(CSR_MINSTRET)),
        .wr_hi (wr_hit(CSR_MINSTRETH)),
        .wdata (csr_write_val),
        .count (w_minstret)
    );

    // Trap beats mret beats a CSR write, decided per register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            if (wr_hit(CSR_MIE))      r_mie      <= csr_write_val & MIE_WMASK;
            if (wr_hit(CSR_MTVEC))    r_mtvec    <= csr_write_val & ALIGN4_MASK;
            if (wr_hit(CSR_MSCRATCH)) r_mscratch <= csr_write_val;
            if (trap_valid) begin
                r_mepc    <= trap_epc & ALIGN4_MASK;
                r_mcause  <= trap_cause;
                r_mtval   <= trap_tval;
                r_mstatus <= {24'b0, r_mstatus[3], 7'b0};
            end else begin
                if (wr_hit(CSR_MEPC))   r_mepc   <= csr_write_val & ALIGN4_MASK;
                if (wr_hit(CSR_MCAUSE)) r_mcause <= csr_write_val;
                if (wr_hit(CSR_MTVAL))  r_mtval  <= csr_write_val;
                if (mret_valid)
                    r_mstatus <= {24'b0, 1'b1, 3'b0, r_mstatus[7], 3'b0};
                else if (wr_hit(CSR_MSTATUS))
                    r_mstatus <= csr_write_val & MSTATUS_WMASK;
            end
        end
    end

    assign w_mip = {20'b0, irq_pending[2], 3'b0, irq_pending[1], 3'b0, irq_pending[0], 3'b0};

    always_comb begin
        w_rdata = '0;
        w_rresp = RRESP_OKAY;
        case (axil_csr_araddr)
            CSR_MSTATUS:                w_rdata = r_mstatus | MSTATUS_MPP;
            CSR_MISA:                   w_rdata = MISA_VAL;
            CSR_MIE:                    w_rdata = r_mie;
            CSR_MTVEC:                  w_rdata = r_mtvec;
            CSR_MSCRATCH:               w_rdata = r_mscratch;
            CSR_MEPC:                   w_rdata = r_mepc;
            CSR_MCAUSE:                 w_rdata = r_mcause;
            CSR_MTVAL:                  w_rdata = r_mtval;
            CSR_MIP:                    w_rdata = w_mip;
            CSR_MCYCLE,   CSR_CYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_minstret[63:32];
            CSR_MHARTID:                w_rdata = '0;
            default:                    w_rresp = RRESP_SLVERR;
        endcase
    end

    assign w_ar_hs = axil_csr_arvalid && (r_state == IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (axil_csr_arvalid) w_state_next = RESP;
            RESP:    if (axil_csr_rready)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_rresp <= RRESP_OKAY;
        end else begin
            r_state <= w_state_next;
            if (w_ar_hs) begin
                r_rdata <= w_rdata;
                r_rresp <= w_rresp;
            end
        end
    end

    assign axil_csr_arready = (r_state == IDLE);
    assign axil_csr_rvalid  = (r_state == RESP);
    assign axil_csr_rdata   = r_rdata;
    assign axil_csr_rresp   = r_rresp;
    assign mtvec_out        = r_mtvec;
    assign mepc_out         = r_mepc;
    assign mie_out          = r_mie;
    assign mstatus_mie_out  = r_mstatus[3];

endmodule
